// File: rtl/sprite_draw_unit.sv
// Sprite overlay stage: per-pixel hit test against frame-latched descriptors,
// sprite-memory addressing, transparency keying and sync delay matched to the colour path.
module sprite_draw_unit #(
  parameter int          SPRITE_SIZE = 32,
  parameter int          SLOTS       = 4,
  parameter int          ADDR_WIDTH  = 12,
  parameter int          IDX_WIDTH   = 2,
  parameter logic [11:0] TRANSPARENT = 12'hF0F
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  video_enable,
  input  logic [10:0]           pixel_x,
  input  logic [9:0]            pixel_y,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic                  reg_write,
  input  logic [1:0]            reg_slot,
  input  logic [10:0]           reg_x,
  input  logic [9:0]            reg_y,
  input  logic [IDX_WIDTH-1:0]  reg_index,
  input  logic                  reg_enable,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [11:0]           mem_data,
  output logic [2:0]            VGA_R,
  output logic [2:0]            VGA_G,
  output logic [2:0]            VGA_B,
  output logic                  hsync,
  output logic                  vsync
);

  localparam int          LOG2   = $clog2(SPRITE_SIZE);
  localparam int          SEL_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int          FULL_W = IDX_WIDTH + 2 * LOG2;
  localparam logic [11:0] EDGE   = 12'(SPRITE_SIZE - 1);

  logic [10:0]          r_stg_x   [SLOTS];
  logic [9:0]           r_stg_y   [SLOTS];
  logic [IDX_WIDTH-1:0] r_stg_idx [SLOTS];
  logic [SLOTS-1:0]     r_stg_en;
  logic [10:0]          r_act_x   [SLOTS];
  logic [9:0]           r_act_y   [SLOTS];
  logic [IDX_WIDTH-1:0] r_act_idx [SLOTS];
  logic [SLOTS-1:0]     r_act_en;

  logic [10:0]          w_eff_x   [SLOTS];
  logic [9:0]           w_eff_y   [SLOTS];
  logic [IDX_WIDTH-1:0] w_eff_idx [SLOTS];
  logic [SLOTS-1:0]     w_eff_en;
  logic [LOG2-1:0]      w_off_x   [SLOTS];
  logic [LOG2-1:0]      w_off_y   [SLOTS];
  logic [SLOTS-1:0]     w_slot_hit;

  logic                 w_frame_start;
  logic                 w_hit;
  logic [SEL_W-1:0]     w_sel;
  logic [FULL_W-1:0]    w_addr_full;

  logic [ADDR_WIDTH-1:0] r_addr_p0;
  logic                  r_vld_p0;
  logic                  r_hs_p0;
  logic                  r_vs_p0;
  logic [8:0]            r_rgb_p1;
  logic                  r_hs_p1;
  logic                  r_vs_p1;

  function automatic logic [8:0] pix_colour(input logic [11:0] word, input logic vld);
    if (vld && (word != TRANSPARENT))
      return {word[11:9], word[7:5], word[3:1]};
    return 9'd0;
  endfunction

  assign w_frame_start = (pixel_x == 11'd0) && (pixel_y == 10'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stg_en <= '0;
      r_act_en <= '0;
      for (int s = 0; s < SLOTS; s++) begin
        r_stg_x[s]   <= '0;
        r_stg_y[s]   <= '0;
        r_stg_idx[s] <= '0;
        r_act_x[s]   <= '0;
        r_act_y[s]   <= '0;
        r_act_idx[s] <= '0;
      end
    end else begin
      for (int s = 0; s < SLOTS; s++) begin
        // Active copy takes the pre-write staging value, so a coincident write waits a frame.
        if (w_frame_start) begin
          r_act_x[s]   <= r_stg_x[s];
          r_act_y[s]   <= r_stg_y[s];
          r_act_idx[s] <= r_stg_idx[s];
          r_act_en[s]  <= r_stg_en[s];
        end
        if (reg_write && (reg_slot == 2'(s))) begin
          r_stg_x[s]   <= reg_x;
          r_stg_y[s]   <= reg_y;
          r_stg_idx[s] <= reg_index;
          r_stg_en[s]  <= reg_enable;
        end
      end
    end
  end

  // Pixel (0,0) already sees the descriptors being latched on that cycle.
  for (genvar s = 0; s < SLOTS; s++) begin : g_slot
    assign w_eff_x[s]   = w_frame_start ? r_stg_x[s]   : r_act_x[s];
    assign w_eff_y[s]   = w_frame_start ? r_stg_y[s]   : r_act_y[s];
    assign w_eff_idx[s] = w_frame_start ? r_stg_idx[s] : r_act_idx[s];
    assign w_eff_en[s]  = w_frame_start ? r_stg_en[s]  : r_act_en[s];
    assign w_off_x[s]   = LOG2'(pixel_x - w_eff_x[s]);
    assign w_off_y[s]   = LOG2'(pixel_y - w_eff_y[s]);
    assign w_slot_hit[s] = w_eff_en[s] && video_enable &&
                           ({1'b0, pixel_x} >= {1'b0, w_eff_x[s]}) &&
                           ({1'b0, pixel_x} <= ({1'b0, w_eff_x[s]} + EDGE)) &&
                           ({2'b0, pixel_y} >= {2'b0, w_eff_y[s]}) &&
                           ({2'b0, pixel_y} <= ({2'b0, w_eff_y[s]} + EDGE));
  end

  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    for (int s = SLOTS - 1; s >= 0; s--) begin
      if (w_slot_hit[s]) begin
        w_hit = 1'b1;
        w_sel = SEL_W'(s);
      end
    end
  end

  assign w_addr_full = {w_eff_idx[w_sel], w_off_y[w_sel], w_off_x[w_sel]};

  // Stage 0 -> 1: address and hit flag registered; address holds between hits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr_p0 <= '0;
      r_vld_p0  <= 1'b0;
      r_hs_p0   <= 1'b0;
      r_vs_p0   <= 1'b0;
    end else begin
      if (w_hit)
        r_addr_p0 <= ADDR_WIDTH'(w_addr_full);
      r_vld_p0 <= w_hit;
      r_hs_p0  <= hsync_in;
      r_vs_p0  <= vsync_in;
    end
  end

  // Stage 1 -> 2: memory word keyed and registered as RGB, sync follows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rgb_p1 <= '0;
      r_hs_p1  <= 1'b0;
      r_vs_p1  <= 1'b0;
    end else begin
      r_rgb_p1 <= pix_colour(mem_data, r_vld_p0);
      r_hs_p1  <= r_hs_p0;
      r_vs_p1  <= r_vs_p0;
    end
  end

  assign mem_addr = r_addr_p0;
  assign VGA_R    = r_rgb_p1[8:6];
  assign VGA_G    = r_rgb_p1[5:3];
  assign VGA_B    = r_rgb_p1[2:0];
  assign hsync    = r_hs_p1;
  assign vsync    = r_vs_p1;

endmodule

// File: tb/tb_sprite_draw_unit.sv
// Bench for sprite_draw_unit: hand vectors for the listed corner cases plus a
// randomized run checked cycle by cycle against a descriptor/frame-level model.
module tb_sprite_draw_unit;

  localparam int SZ = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        video_enable = 1'b0;
  logic [10:0] pixel_x = '0;
  logic [9:0]  pixel_y = '0;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic        reg_write = 1'b0;
  logic [1:0]  reg_slot = '0;
  logic [10:0] reg_x = '0;
  logic [9:0]  reg_y = '0;
  logic [1:0]  reg_index = '0;
  logic        reg_enable = 1'b0;
  logic [11:0] mem_addr;
  logic [11:0] mem_data;
  logic [2:0]  VGA_R, VGA_G, VGA_B;
  logic        hsync, vsync;

  logic [11:0] mem [4096];
  assign mem_data = mem[mem_addr];

  always #10 clk = ~clk;

  sprite_draw_unit #(
    .SPRITE_SIZE(32), .SLOTS(4), .ADDR_WIDTH(12), .IDX_WIDTH(2), .TRANSPARENT(12'hF0F)
  ) dut (
    .clk(clk), .reset(reset), .video_enable(video_enable),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .reg_write(reg_write), .reg_slot(reg_slot), .reg_x(reg_x), .reg_y(reg_y),
    .reg_index(reg_index), .reg_enable(reg_enable),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .hsync(hsync), .vsync(vsync)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { int x; int y; int idx; bit en; } desc_t;
  desc_t m_stg [4];
  desc_t m_act [4];
  int q_rgb1, q_rgb2, q_addr;
  bit q_hs1, q_hs2, q_vs1, q_vs2;

  typedef struct { int phase; int px; int py; bit ve; int exp_addr; int exp_rgb; } vec_t;
  vec_t tbl [$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rgb_now();
    return int'({VGA_R, VGA_G, VGA_B});
  endfunction

  function automatic int colour(input logic [11:0] w);
    if (w == 12'hF0F) return 0;
    return int'(w[11:9]) * 64 + int'(w[7:5]) * 8 + int'(w[3:1]);
  endfunction

  // Reference: lowest enabled slot whose square contains the pixel wins.
  function automatic void model_pixel(output bit hit, output int addr, output int rgb);
    desc_t d;
    int px, py;
    hit = 0; addr = 0; rgb = 0;
    px = int'(pixel_x);
    py = int'(pixel_y);
    if (!video_enable) return;
    for (int s = 0; s < 4; s++) begin
      d = (px == 0 && py == 0) ? m_stg[s] : m_act[s];
      if (d.en && px >= d.x && px < d.x + SZ && py >= d.y && py < d.y + SZ) begin
        hit  = 1;
        addr = (d.idx * SZ * SZ + (py - d.y) * SZ + (px - d.x)) % 4096;
        rgb  = colour(mem[addr]);
        return;
      end
    end
  endfunction

  task automatic model_clear();
    for (int s = 0; s < 4; s++) begin
      m_stg[s] = '{0, 0, 0, 1'b0};
      m_act[s] = '{0, 0, 0, 1'b0};
    end
    q_rgb1 = 0; q_rgb2 = 0; q_addr = 0;
    q_hs1 = 0; q_hs2 = 0; q_vs1 = 0; q_vs2 = 0;
  endtask

  // One clock: model evaluates the current inputs, DUT outputs are compared at the negedge.
  task automatic tick();
    bit hit;
    int addr, rgb;
    model_pixel(hit, addr, rgb);
    if (pixel_x == 0 && pixel_y == 0) m_act = m_stg;
    if (reg_write) begin
      m_stg[reg_slot].x   = int'(reg_x);
      m_stg[reg_slot].y   = int'(reg_y);
      m_stg[reg_slot].idx = int'(reg_index);
      m_stg[reg_slot].en  = reg_enable;
    end
    @(posedge clk);
    q_rgb2 = q_rgb1; q_rgb1 = rgb;
    q_hs2 = q_hs1; q_hs1 = hsync_in;
    q_vs2 = q_vs1; q_vs1 = vsync_in;
    if (hit) q_addr = addr;
    @(negedge clk);
    check("model_rgb", rgb_now(), q_rgb2);
    check("model_addr", int'(mem_addr), q_addr);
    check("model_sync", int'({hsync, vsync}), int'({q_hs2, q_vs2}));
    reg_write = 1'b0;
  endtask

  task automatic set_pix(input int x, input int y, input bit ve);
    pixel_x = 11'(x);
    pixel_y = 10'(y);
    video_enable = ve;
    hsync_in = 1'($urandom_range(0, 1));
    vsync_in = 1'($urandom_range(0, 1));
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    check("reset_rgb", rgb_now(), 0);
    check("reset_addr", int'(mem_addr), 0);
    check("reset_sync", int'({hsync, vsync}), 0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic write_slot(input int s, input int x, input int y, input int idx, input bit en);
    set_pix(5, 5, 1'b0);
    reg_slot = 2'(s); reg_x = 11'(x); reg_y = 10'(y);
    reg_index = 2'(idx); reg_enable = en; reg_write = 1'b1;
    tick();
  endtask

  task automatic new_frame();
    set_pix(0, 0, 1'b0);
    tick();
  endtask

  task automatic fill(input int lo, input int hi, input logic [11:0] w);
    set_pix(5, 5, 1'b0);
    tick(); tick();
    for (int a = lo; a <= hi; a++) mem[a] = w;
  endtask

  task automatic run_phase(input int phase);
    foreach (tbl[i]) begin
      if (tbl[i].phase == phase) begin
        set_pix(tbl[i].px, tbl[i].py, tbl[i].ve);
        tick();
        if (tbl[i].exp_addr >= 0)
          check($sformatf("vec%0d_addr", i), int'(mem_addr), tbl[i].exp_addr);
        tick();
        check($sformatf("vec%0d_rgb", i), rgb_now(), tbl[i].exp_rgb);
      end
    end
  endtask

  task automatic scan_row(input int y, input int x0, input int x1);
    for (int x = x0; x <= x1; x++) begin
      set_pix(x, y, 1'b1);
      tick();
    end
  endtask

  initial begin
    int s, bx, by;
    // E4A -> (7,2,5)=469, 0F0 -> (0,7,0)=56, F00 -> (7,0,0)=448, A5C -> (5,2,6)=342
    tbl.push_back('{1, 300, 300, 1'b1, 1024, 469});
    tbl.push_back('{1, 331, 331, 1'b1, 2047, 469});
    tbl.push_back('{1, 315, 305, 1'b1, 1199, 469});
    tbl.push_back('{1, 332, 300, 1'b1, -1, 0});
    tbl.push_back('{1, 299, 300, 1'b1, -1, 0});
    tbl.push_back('{1, 300, 332, 1'b1, -1, 0});
    tbl.push_back('{1, 310, 310, 1'b0, -1, 0});
    tbl.push_back('{2, 100, 100, 1'b1, 0, 56});
    tbl.push_back('{2, 95, 95, 1'b1, 2048 + 5 * 32 + 5, 448});
    tbl.push_back('{2, 125, 125, 1'b1, 25 * 32 + 25, 56});
    tbl.push_back('{3, 100, 100, 1'b1, 0, 0});
    tbl.push_back('{3, 95, 95, 1'b1, -1, 448});
    tbl.push_back('{4, 790, 60, 1'b1, 3072 + 10 * 32, 342});
    tbl.push_back('{4, 799, 60, 1'b1, 3072 + 10 * 32 + 9, 342});
    tbl.push_back('{4, 789, 60, 1'b1, -1, 0});
    tbl.push_back('{4, 0, 60, 1'b1, -1, 0});
    tbl.push_back('{4, 21, 60, 1'b1, -1, 0});
    tbl.push_back('{5, 310, 305, 1'b1, -1, 469});
    tbl.push_back('{5, 15, 305, 1'b1, -1, 0});
    tbl.push_back('{6, 15, 305, 1'b1, 1024 + 5 * 32 + 5, 469});
    tbl.push_back('{6, 310, 305, 1'b1, -1, 0});
    tbl.push_back('{7, 15, 305, 1'b1, -1, 469});
    tbl.push_back('{7, 510, 305, 1'b1, -1, 0});
    tbl.push_back('{8, 510, 305, 1'b1, 1024 + 5 * 32 + 10, 469});
    tbl.push_back('{8, 15, 305, 1'b1, -1, 0});

    for (int a = 0; a < 4096; a++) mem[a] = 12'($urandom);
    model_clear();
    #5;
    apply_reset();

    // No descriptors written: everything black, sync delayed by two.
    for (int i = 0; i < 1500; i++) begin
      if (i % 500 == 0) set_pix(0, 0, 1'b1);
      else set_pix($urandom_range(0, 850), $urandom_range(0, 530), 1'($urandom_range(0, 1)));
      tick();
    end

    fill(0, 4095, 12'hE4A);
    write_slot(0, 300, 300, 1, 1'b1);
    new_frame();
    run_phase(1);
    scan_row(300, 290, 340);

    write_slot(0, 100, 100, 0, 1'b1);
    write_slot(1, 90, 90, 2, 1'b1);
    fill(0, 1023, 12'h0F0);
    fill(2048, 3071, 12'hF00);
    new_frame();
    run_phase(2);
    fill(0, 1023, 12'hF0F);
    run_phase(3);
    scan_row(95, 85, 135);

    write_slot(0, 790, 50, 3, 1'b1);
    write_slot(1, 0, 0, 0, 1'b0);
    fill(3072, 4095, 12'hA5C);
    new_frame();
    run_phase(4);
    scan_row(60, 780, 825);
    scan_row(60, 0, 25);

    fill(1024, 2047, 12'hE4A);
    write_slot(0, 300, 300, 1, 1'b1);
    new_frame();
    set_pix(400, 200, 1'b1);
    reg_slot = 2'd0; reg_x = 11'd10; reg_y = 10'd300; reg_index = 2'd1; reg_enable = 1'b1;
    reg_write = 1'b1;
    tick();
    run_phase(5);
    new_frame();
    run_phase(6);
    set_pix(0, 0, 1'b0);
    reg_slot = 2'd0; reg_x = 11'd500; reg_y = 10'd300; reg_index = 2'd1; reg_enable = 1'b1;
    reg_write = 1'b1;
    tick();
    run_phase(7);
    new_frame();
    run_phase(8);

    // Reset while a sprite pixel is on screen.
    write_slot(0, 300, 300, 1, 1'b1);
    new_frame();
    set_pix(310, 305, 1'b1);
    tick(); tick();
    check("pre_reset_rgb", rgb_now(), 469);
    apply_reset();
    for (int i = 0; i < 4; i++) tick();
    check("post_reset_rgb", rgb_now(), 0);
    new_frame();
    scan_row(305, 300, 335);

    // Randomized run against the model.
    for (int a = 0; a < 4096; a++)
      mem[a] = ($urandom_range(0, 7) == 0) ? 12'hF0F : 12'($urandom);
    for (int k = 0; k < 4; k++)
      write_slot(k, $urandom_range(0, 800), $urandom_range(0, 520), $urandom_range(0, 3), 1'b1);
    new_frame();
    for (int i = 0; i < 18000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        set_pix(0, 0, 1'($urandom_range(0, 1)));
      end else if ($urandom_range(0, 9) < 7) begin
        s  = $urandom_range(0, 3);
        bx = m_act[s].x + $urandom_range(0, 40) - 4;
        by = m_act[s].y + $urandom_range(0, 40) - 4;
        if (bx < 0) bx = 0;
        if (by < 0) by = 0;
        if (bx > 2047) bx = 2047;
        if (by > 1023) by = 1023;
        set_pix(bx, by, 1'($urandom_range(0, 9) != 0));
      end else begin
        set_pix($urandom_range(0, 850), $urandom_range(0, 530), 1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 49) == 0) begin
        reg_slot = 2'($urandom_range(0, 3));
        reg_x = 11'($urandom_range(0, 800));
        reg_y = 10'($urandom_range(0, 520));
        reg_index = 2'($urandom_range(0, 3));
        reg_enable = 1'($urandom_range(0, 4) != 0);
        reg_write = 1'b1;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_draw_unit.md
Name: sprite_draw_unit

Overview:
- Pixel-pipeline stage between SVGA_sync and the VGA output pins; drives memorySprites.
- Holds SLOTS sprite descriptors (position, sprite index, enable) and tests each incoming pixel against them.
- Generates the sprite-memory read address, absorbs the 1-cycle memory latency, applies transparency and emits 3-bit RGB.
- Delays hsync/vsync so that colour and sync stay aligned.

Parameters:
- SPRITE_SIZE, 32, sprite edge in pixels; power of two.
- SLOTS, 4, number of sprite descriptors; slot 0 has highest priority.
- ADDR_WIDTH, 12, sprite-memory address width.
- IDX_WIDTH, 2, sprite-index width; the index selects a SPRITE_SIZE*SPRITE_SIZE block in memory.
- TRANSPARENT, 12'hF0F, memory word treated as see-through.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high reset.
- video_enable  in  1  active-area flag from SVGA_sync.
- pixel_x  in  11  current pixel column.
- pixel_y  in  10  current pixel row.
- hsync_in  in  1  hsync from SVGA_sync.
- vsync_in  in  1  vsync from SVGA_sync.
- reg_write  in  1  one-cycle descriptor write strobe.
- reg_slot  in  2  descriptor slot to write.
- reg_x  in  11  sprite left column.
- reg_y  in  10  sprite top row.
- reg_index  in  IDX_WIDTH  sprite image index.
- reg_enable  in  1  slot visible.
- mem_addr  out  ADDR_WIDTH  read address to memorySprites.
- mem_data  in  12  memory word; valid 1 cycle after mem_addr.
- VGA_R, VGA_G, VGA_B  out  3 each  colour outputs.
- hsync, vsync  out  1 each  sync delayed 2 cycles.

Behaviour:
- Reset (async):
  - All descriptors cleared: x=0, y=0, index=0, enable=0.
  - mem_addr=0, VGA_R/G/B=0.
  - hsync and vsync outputs = 0.
  - All pipeline valid bits = 0.
- Descriptor storage:
  - On reg_write, the selected slot's staging register is loaded.
  - The active copy is loaded from staging on the cycle where pixel_x==0 && pixel_y==0. Changes therefore appear only at a frame boundary; no tearing.
  - If reg_write coincides with a frame-boundary load, the new write lands in staging only and takes effect next frame.
- Stage 0 (cycle t):
  - Slot s hits when all of: enable, video_enable, reg_x <= pixel_x <= reg_x+SPRITE_SIZE-1, reg_y <= pixel_y <= reg_y+SPRITE_SIZE-1.
  - Comparisons use 12-bit sums, so there is no wrap. Sprites are clipped at screen edges with no wrap to column 0.
  - Winner is the lowest-numbered hit slot.
  - mem_addr <= index*SIZE*SIZE + (pixel_y-reg_y)*SIZE + (pixel_x-reg_x), truncated to ADDR_WIDTH, registered.
  - hit flag registered alongside mem_addr.
  - With no hit, mem_addr holds its previous value.
- Stage 1 (t+1): memory returns mem_data; hit flag is delayed one more cycle.
- Stage 2 (t+2): RGB registered.
  - If hit and mem_data != TRANSPARENT: R=mem_data[11:9], G=mem_data[7:5], B=mem_data[3:1].
  - Otherwise (no hit, transparent, or video_enable low at t): R=G=B=0.
  - Transparency does not fall through to lower-priority slots; the output is black.
- Latency: exactly 2 cycles from pixel_x/pixel_y to RGB. hsync/vsync pass through a matching 2-stage delay.
- No throughput stall: one pixel per clock continuously.
- Reset mid-frame: outputs go to 0 immediately. The pipeline refills 2 cycles after reset deasserts, and descriptors stay disabled until written.

Test Plan:
- Reset, then scan a full frame with no writes -> RGB=0 every cycle; hsync/vsync equal inputs delayed by 2 cycles.
- Slot 0 = (x=300, y=300, idx=1, en=1), memory word 12'hE4A everywhere, next frame -> RGB=(7,2,5) at pixel (300,300) two cycles later:
  - mem_addr=1024 at (300,300) and 1024+32*31+31=2047 at (331,331).
  - Pixels 332 and 299 produce 0.
- Slots 0 and 1 overlapping at (100,100): slot 0 idx0 word 12'h0F0, slot 1 idx2 word 12'hF00 -> overlap shows G=7, R=0.
- Slot 0 word = 12'hF0F over a slot 1 area -> output 0, not slot 1 colour.
- Slot at x=790 on an 800-wide screen -> columns 790..799 drawn; columns 0..21 of the same row not drawn.
- Write slot 0 x=10 mid-frame at pixel (400,200) -> remainder of frame still uses the old x; new x is used from (0,0) of the next frame. Assert reset at (310,305) -> RGB=0 within the same cycle.
